branch_predict_btb: RTL

- N-entry direct-mapped branch predictor: each entry holds a tag, a branch target and a 2-bit saturating direction counter.
- Fetch stage presents a PC and receives a taken prediction plus target in the same cycle.
- Execute stage returns the resolved outcome to train the table.
- Successor to the single-entry 3-state predictor: more entries, per-entry targets, full 2-bit hysteresis, optional global-history indexing.

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_sat_counter.sv | 23 ++
 rtl/branch_predict_btb.sv | 103 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the BTB branch predictor:
// counter encodings and the PC-to-tag helper.
package bp_pkg;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  // Tag is everything above the index and byte-offset bits.
  // The caller narrows the result to its tag width.
  function automatic logic [31:0] pc_tag(
    input logic [31:0] pc,
    input int unsigned idx_w
  );
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating direction counter.
// force_wt takes priority and yields weak-taken.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  input  logic       force_wt,
  output logic [1:0] cnt_next
);

  // Saturate at the ends, step by one otherwise.
  always_comb begin
    cnt_next = cnt;
    if (force_wt)
      cnt_next = CNT_WT;
    else if (taken)
      cnt_next = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    else
      cnt_next = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
  end

endmodule

// File: rtl/branch_predict_btb.sv
// Direct-mapped BTB with 2-bit counters and per-entry targets.
// Optional gshare indexing when BP_GSHARE_EN is defined.
module branch_predict_btb
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [IDX_W-1:0] pred_hist,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic [IDX_W-1:0] upd_hist
);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];

  logic [IDX_W-1:0] hist;
  logic [IDX_W-1:0] uh;
  logic [IDX_W-1:0] lidx;
  logic [IDX_W-1:0] uidx;
  logic [TAG_W-1:0] ltag;
  logic [TAG_W-1:0] utag;
  logic             uhit;
  logic             force_wt;
  logic [1:0]       cnt_next;
  logic             unused_bits;

  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_hist};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // Shift each resolved direction into the global history.
  always_ff @(posedge clk) begin
    if (rst)
      ghr <= '0;
    else if (upd_valid)
      ghr <= (ghr << 1) | IDX_W'(upd_taken);
  end

  assign hist = ghr;
  assign uh   = upd_hist;
`else
  assign hist = '0;
  assign uh   = '0;
`endif

  assign lidx = lookup_pc[IDX_W+1:2] ^ hist;
  assign uidx = upd_pc[IDX_W+1:2] ^ uh;
  assign ltag = TAG_W'(pc_tag(lookup_pc, IDX_W));
  assign utag = TAG_W'(pc_tag(upd_pc, IDX_W));

  assign pred_hit    = valid_q[lidx] && (tag_q[lidx] == ltag);
  assign pred_taken  = pred_hit && cnt_q[lidx][1];
  assign pred_target = pred_hit ? tgt_q[lidx] : 32'd0;
  assign pred_hist   = hist;

  assign uhit     = valid_q[uidx] && (tag_q[uidx] == utag);
  assign force_wt = upd_taken && (upd_target != tgt_q[uidx]);

  bp_sat_counter u_cnt (
    .cnt      (cnt_q[uidx]),
    .taken    (upd_taken),
    .force_wt (force_wt),
    .cnt_next (cnt_next)
  );

  // Train on a hit, allocate on a taken miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_SNT;
      end
    end else if (upd_valid) begin
      if (uhit) begin
        cnt_q[uidx] <= cnt_next;
        if (force_wt)
          tgt_q[uidx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx]   <= utag;
        tgt_q[uidx]   <= upd_target;
        cnt_q[uidx]   <= CNT_WT;
      end
    end
  end

endmodule
